// File: rtl/clint_mmio_master_pkg.sv
// rtl/clint_mmio_master_pkg.sv - shared encodings, window constants and FSM states for the CLINT MMIO master
package clint_mmio_master_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [63:0] CLINT_BASE   = 64'h0000_0000_0200_0000;
   localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
   localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_WR,
      ST_RESP
   } state_t;

   // Low address bits that must be zero for a naturally aligned access
   function automatic logic [2:0] lane_mask(input logic [1:0] size);
      case (size)
         SZ_B:    lane_mask = 3'b000;
         SZ_H:    lane_mask = 3'b001;
         SZ_W:    lane_mask = 3'b011;
         default: lane_mask = 3'b111;
      endcase
   endfunction

   // Byte enables of an access of the given size starting at lane 0
   function automatic logic [7:0] byte_mask(input logic [1:0] size);
      case (size)
         SZ_B:    byte_mask = 8'h01;
         SZ_H:    byte_mask = 8'h03;
         SZ_W:    byte_mask = 8'h0F;
         default: byte_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/clint_lane_align.sv
// rtl/clint_lane_align.sv - sub-doubleword load extract/extend and store byte-merge
module clint_lane_align (
   input  logic [63:0] data,
   input  logic [63:0] wdata,
   input  logic [2:0]  lane,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [63:0] load_data,
   output logic [63:0] merge_data
);
   import clint_mmio_master_pkg::*;

   logic [63:0] shifted;
   logic [63:0] wshift;
   logic [7:0]  bmask;

   assign shifted = data >> {lane, 3'b000};
   assign wshift  = wdata << {lane, 3'b000};
   assign bmask   = byte_mask(size) << lane;

   // Right-align the addressed bytes and extend to a full doubleword
   always_comb begin
      load_data = shifted;
      case (size)
         SZ_B:    load_data = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
         SZ_H:    load_data = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
         SZ_W:    load_data = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
         default: load_data = shifted;
      endcase
   end

   // Overlay the low store bytes onto the old doubleword at the addressed lanes
   always_comb begin
      merge_data = data;
      for (int i = 0; i < 8; i++) begin
         if (bmask[i]) begin
            merge_data[8*i +: 8] = wshift[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/clint_mmio_master.sv
// rtl/clint_mmio_master.sv - LSU-side initiator turning one load/store into CLINT read/write strobes
module clint_mmio_master #(
   parameter logic [63:0] CLINT_BASE = clint_mmio_master_pkg::CLINT_BASE,
   parameter int unsigned DATA_W     = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [63:0]       req_addr_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_signed_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DATA_W-1:0] resp_rdata_o,
   output logic              resp_err_o,
   output logic              clint_re_o,
   output logic [15:0]       clint_raddr_o,
   input  logic [DATA_W-1:0] clint_rdata_i,
   output logic              clint_we_o,
   output logic [15:0]       clint_waddr_o,
   output logic [DATA_W-1:0] clint_wdata_o
);
   import clint_mmio_master_pkg::*;

   state_t      state, state_d;
   logic        we_q, we_d;
   logic [12:0] dw_q, dw_d;
   logic [2:0]  lane_q, lane_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] dbuf_q, dbuf_d;
   logic        resp_valid_d, resp_err_d;
   logic [63:0] resp_rdata_d;
   logic        re_d, wr_d;
   logic [15:0] raddr_d, waddr_d;
   logic [63:0] cwdata_d;
   logic [63:0] load_data, merge_data;
   logic        req_err;

   clint_lane_align u_align (
      .data       (clint_rdata_i),
      .wdata      (wdata_q),
      .lane       (lane_q),
      .size       (size_q),
      .sign_ext   (sgn_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   assign req_err = (req_addr_i[63:16] != CLINT_BASE[63:16]) ||
                    ((req_addr_i[2:0] & lane_mask(req_size_i)) != 3'b000);

   assign req_ready_o = (state == ST_IDLE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next state plus next values of every registered output and buffer
   always_comb begin
      state_d      = state;
      we_d         = we_q;
      dw_d         = dw_q;
      lane_d       = lane_q;
      size_d       = size_q;
      sgn_d        = sgn_q;
      wdata_d      = wdata_q;
      dbuf_d       = dbuf_q;
      resp_valid_d = resp_valid_o;
      resp_err_d   = resp_err_o;
      resp_rdata_d = resp_rdata_o;
      re_d         = 1'b0;
      wr_d         = 1'b0;
      raddr_d      = clint_raddr_o;
      waddr_d      = clint_waddr_o;
      cwdata_d     = clint_wdata_o;
      case (state)
         ST_IDLE: begin
            if (req_valid_i) begin
               we_d    = req_we_i;
               dw_d    = req_addr_i[15:3];
               lane_d  = req_addr_i[2:0];
               size_d  = req_size_i;
               sgn_d   = req_signed_i;
               wdata_d = req_wdata_i;
               if (req_err) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else if (req_we_i && req_size_i == SZ_D) begin
                  state_d  = ST_WR;
                  wr_d     = 1'b1;
                  waddr_d  = {req_addr_i[15:3], 3'b000};
                  cwdata_d = req_wdata_i;
               end else begin
                  state_d = ST_RD;
                  re_d    = 1'b1;
                  raddr_d = {req_addr_i[15:3], 3'b000};
               end
            end
         end
         ST_RD: begin
            state_d = ST_CAP;
         end
         ST_CAP: begin
            if (we_q) begin
               state_d  = ST_WR;
               dbuf_d   = merge_data;
               wr_d     = 1'b1;
               waddr_d  = {dw_q, 3'b000};
               cwdata_d = merge_data;
            end else begin
               state_d      = ST_RESP;
               dbuf_d       = clint_rdata_i;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = load_data;
            end
         end
         ST_WR: begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
         end
         ST_RESP: begin
            if (resp_ready_i) begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered outputs and transaction buffers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q          <= 1'b0;
         dw_q          <= '0;
         lane_q        <= '0;
         size_q        <= '0;
         sgn_q         <= 1'b0;
         wdata_q       <= '0;
         dbuf_q        <= '0;
         resp_valid_o  <= 1'b0;
         resp_err_o    <= 1'b0;
         resp_rdata_o  <= '0;
         clint_re_o    <= 1'b0;
         clint_raddr_o <= '0;
         clint_we_o    <= 1'b0;
         clint_waddr_o <= '0;
         clint_wdata_o <= '0;
      end else begin
         we_q          <= we_d;
         dw_q          <= dw_d;
         lane_q        <= lane_d;
         size_q        <= size_d;
         sgn_q         <= sgn_d;
         wdata_q       <= wdata_d;
         dbuf_q        <= dbuf_d;
         resp_valid_o  <= resp_valid_d;
         resp_err_o    <= resp_err_d;
         resp_rdata_o  <= resp_rdata_d;
         clint_re_o    <= re_d;
         clint_raddr_o <= raddr_d;
         clint_we_o    <= wr_d;
         clint_waddr_o <= waddr_d;
         clint_wdata_o <= cwdata_d;
      end
   end

endmodule

// File: tb/tb_clint_mmio_master.sv
// tb/tb_clint_mmio_master.sv - directed vector bench for clint_mmio_master
module tb_clint_mmio_master;
   import clint_mmio_master_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [63:0] req_addr_i = '0;
   logic [1:0]  req_size_i = '0;
   logic        req_signed_i = 1'b0;
   logic [63:0] req_wdata_i = '0;
   logic        resp_valid_o;
   logic        resp_ready_i = 1'b0;
   logic [63:0] resp_rdata_o;
   logic        resp_err_o;
   logic        clint_re_o;
   logic [15:0] clint_raddr_o;
   logic [63:0] clint_rdata_i = '0;
   logic        clint_we_o;
   logic [15:0] clint_waddr_o;
   logic [63:0] clint_wdata_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clint_mmio_master dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_we_i      (req_we_i),
      .req_addr_i    (req_addr_i),
      .req_size_i    (req_size_i),
      .req_signed_i  (req_signed_i),
      .req_wdata_i   (req_wdata_i),
      .resp_valid_o  (resp_valid_o),
      .resp_ready_i  (resp_ready_i),
      .resp_rdata_o  (resp_rdata_o),
      .resp_err_o    (resp_err_o),
      .clint_re_o    (clint_re_o),
      .clint_raddr_o (clint_raddr_o),
      .clint_rdata_i (clint_rdata_i),
      .clint_we_o    (clint_we_o),
      .clint_waddr_o (clint_waddr_o),
      .clint_wdata_o (clint_wdata_o)
   );

   // CLINT register port model: read data appears the cycle after re
   logic [63:0] clint_val = '0;
   int          re_cnt = 0;
   int          we_cnt = 0;
   logic [15:0] last_raddr = '0;
   logic [15:0] last_waddr = '0;
   logic [63:0] last_wdata = '0;

   always @(posedge clk) begin
      if (clint_re_o) begin
         clint_rdata_i <= clint_val;
         re_cnt        <= re_cnt + 1;
         last_raddr    <= clint_raddr_o;
      end
      if (clint_we_o) begin
         we_cnt     <= we_cnt + 1;
         last_waddr <= clint_waddr_o;
         last_wdata <= clint_wdata_o;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request from a negedge; lat = extra posedges after acceptance until resp_valid
   task automatic do_req(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [63:0] wdata, output int lat);
      int w;
      w = 0;
      while (!req_ready_o && w < 10) begin
         @(negedge clk);
         w++;
      end
      req_valid_i  = 1'b1;
      req_we_i     = we;
      req_addr_i   = addr;
      req_size_i   = size;
      req_signed_i = sgn;
      req_wdata_i  = wdata;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         if (resp_valid_o) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic finish_resp(input string name);
      resp_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready_i = 1'b0;
      chk({name, " ready_after"}, {63'd0, req_ready_o}, 64'd1);
      chk({name, " valid_after"}, {63'd0, resp_valid_o}, 64'd0);
   endtask

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [1:0]  size;
      logic        sgn;
      logic [63:0] wdata;
      logic [63:0] cval;
      int          lat;
      logic [63:0] rdata;
      logic        err;
      int          nre;
      int          nwe;
      logic [15:0] raddr;
      logic [15:0] waddr;
      logic [63:0] wd;
   } vec_t;

   vec_t vecs[15];

   initial begin
      int lat;
      logic [63:0] held;

      // we, addr, size, sgn, wdata, cval, lat, rdata, err, nre, nwe, raddr, waddr, wd
      vecs[0]  = '{1'b0, CLINT_BASE | 64'(MTIME_OFF), SZ_D, 1'b0, 64'h0, 64'h0000_0000_1234_5678, 2, 64'h0000_0000_1234_5678, 1'b0, 1, 0, 16'hBFF8, 16'h0, 64'h0};
      vecs[1]  = '{1'b0, 64'h0200_4004, SZ_W, 1'b1, 64'h0, 64'h8000_0001_0000_0000, 2, 64'hFFFF_FFFF_8000_0001, 1'b0, 1, 0, 16'h4000, 16'h0, 64'h0};
      vecs[2]  = '{1'b0, 64'h0200_4004, SZ_W, 1'b0, 64'h0, 64'h8000_0001_0000_0000, 2, 64'h0000_0000_8000_0001, 1'b0, 1, 0, 16'h4000, 16'h0, 64'h0};
      vecs[3]  = '{1'b0, 64'h0200_4007, SZ_B, 1'b1, 64'h0, 64'h8000_0001_0000_0000, 2, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1, 0, 16'h4000, 16'h0, 64'h0};
      vecs[4]  = '{1'b0, 64'h0200_0002, SZ_H, 1'b0, 64'h0, 64'h1111_2222_3333_4444, 2, 64'h0000_0000_0000_3333, 1'b0, 1, 0, 16'h0000, 16'h0, 64'h0};
      vecs[5]  = '{1'b0, 64'h0200_0004, SZ_H, 1'b1, 64'h0, 64'h1111_A222_3333_4444, 2, 64'hFFFF_FFFF_FFFF_A222, 1'b0, 1, 0, 16'h0000, 16'h0, 64'h0};
      vecs[6]  = '{1'b0, 64'h0200_8000, SZ_D, 1'b0, 64'h0, 64'h5555_AAAA_0F0F_F0F0, 2, 64'h5555_AAAA_0F0F_F0F0, 1'b0, 1, 0, 16'h8000, 16'h0, 64'h0};
      vecs[7]  = '{1'b1, 64'h0200_4002, SZ_B, 1'b0, 64'hFFFF_FFFF_FFFF_FFAB, 64'h1111_2222_3333_4444, 3, 64'h0, 1'b0, 1, 1, 16'h4000, 16'h4000, 64'h1111_2222_33AB_4444};
      vecs[8]  = '{1'b1, 64'h0200_4006, SZ_H, 1'b0, 64'h0000_0000_1234_BEEF, 64'h1111_2222_3333_4444, 3, 64'h0, 1'b0, 1, 1, 16'h4000, 16'h4000, 64'hBEEF_2222_3333_4444};
      vecs[9]  = '{1'b1, 64'h0200_4004, SZ_W, 1'b0, 64'h7777_7777_CAFE_BABE, 64'h1111_2222_3333_4444, 3, 64'h0, 1'b0, 1, 1, 16'h4000, 16'h4000, 64'hCAFE_BABE_3333_4444};
      vecs[10] = '{1'b1, CLINT_BASE | 64'(MTIMECMP_OFF), SZ_D, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0, 1, 64'h0, 1'b0, 0, 1, 16'h0, 16'h4000, 64'hDEAD_BEEF_0000_0001};
      vecs[11] = '{1'b0, 64'h0300_0000, SZ_D, 1'b0, 64'h0, 64'h0, 0, 64'h0, 1'b1, 0, 0, 16'h0, 16'h0, 64'h0};
      vecs[12] = '{1'b0, 64'h0200_4003, SZ_H, 1'b0, 64'h0, 64'h0, 0, 64'h0, 1'b1, 0, 0, 16'h0, 16'h0, 64'h0};
      vecs[13] = '{1'b1, 64'h0200_4002, SZ_W, 1'b0, 64'h1234, 64'h0, 0, 64'h0, 1'b1, 0, 0, 16'h0, 16'h0, 64'h0};
      vecs[14] = '{1'b1, 64'h1_0200_0000, SZ_D, 1'b0, 64'h1234, 64'h0, 0, 64'h0, 1'b1, 0, 0, 16'h0, 16'h0, 64'h0};

      // Reset state
      #2;
      chk("rst req_ready", {63'd0, req_ready_o}, 64'd1);
      chk("rst resp_valid", {63'd0, resp_valid_o}, 64'd0);
      chk("rst resp_err", {63'd0, resp_err_o}, 64'd0);
      chk("rst resp_rdata", resp_rdata_o, 64'd0);
      chk("rst strobes", {62'd0, clint_re_o, clint_we_o}, 64'd0);
      chk("rst addrs", {32'd0, clint_raddr_o, clint_waddr_o}, 64'd0);
      chk("rst wdata", clint_wdata_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven transactions
      for (int i = 0; i < 15; i++) begin
         re_cnt    = 0;
         we_cnt    = 0;
         clint_val = vecs[i].cval;
         do_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].wdata, lat);
         if (lat < 0) $display("FAIL v%0d resp_timeout: no resp_valid within 20 cycles", i);
         chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
         chk($sformatf("v%0d rdata", i), resp_rdata_o, vecs[i].rdata);
         chk($sformatf("v%0d err", i), {63'd0, resp_err_o}, {63'd0, vecs[i].err});
         chk($sformatf("v%0d re_count", i), 64'(re_cnt), 64'(vecs[i].nre));
         chk($sformatf("v%0d we_count", i), 64'(we_cnt), 64'(vecs[i].nwe));
         if (vecs[i].nre > 0) chk($sformatf("v%0d raddr", i), 64'(last_raddr), 64'(vecs[i].raddr));
         if (vecs[i].nwe > 0) begin
            chk($sformatf("v%0d waddr", i), 64'(last_waddr), 64'(vecs[i].waddr));
            chk($sformatf("v%0d wdata", i), last_wdata, vecs[i].wd);
         end
         finish_resp($sformatf("v%0d", i));
      end

      // Response held with resp_ready low while another request waits
      re_cnt    = 0;
      clint_val = 64'h1111_2222_3333_4444;
      do_req(1'b0, 64'h0200_0002, SZ_H, 1'b0, 64'h0, lat);
      chk("hold latency", 64'(lat), 64'd2);
      held = resp_rdata_o;
      req_valid_i = 1'b1;
      req_addr_i  = 64'h0200_4000;
      req_size_i  = SZ_D;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("hold%0d valid", c), {63'd0, resp_valid_o}, 64'd1);
         chk($sformatf("hold%0d rdata", c), resp_rdata_o, 64'h3333);
         chk($sformatf("hold%0d ready", c), {63'd0, req_ready_o}, 64'd0);
      end
      req_valid_i = 1'b0;
      chk("hold stable", resp_rdata_o, held);
      chk("hold re_count", 64'(re_cnt), 64'd1);
      finish_resp("hold");

      // Async reset while a partial store sits in CAP
      re_cnt       = 0;
      we_cnt       = 0;
      clint_val    = 64'h1111_2222_3333_4444;
      req_valid_i  = 1'b1;
      req_we_i     = 1'b1;
      req_addr_i   = 64'h0200_4002;
      req_size_i   = SZ_B;
      req_wdata_i  = 64'hAB;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      chk("rmw re_high", {63'd0, clint_re_o}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst req_ready", {63'd0, req_ready_o}, 64'd1);
      chk("arst raddr", 64'(clint_raddr_o), 64'd0);
      chk("arst outs", {61'd0, clint_re_o, clint_we_o, resp_valid_o}, 64'd0);
      chk("arst wdata", clint_wdata_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("arst no_write", 64'(we_cnt), 64'd0);
      chk("arst idle", {63'd0, req_ready_o}, 64'd1);
      chk("arst no_resp", {63'd0, resp_valid_o}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clint_mmio_master.md
Name: clint_mmio_master

Overview:
- Core-side initiator for the CLINT register port: turns one load/store request from the LSU into CLINT read/write strobes.
- Decodes the CLINT address window and extracts or sign-extends sub-doubleword loads.
- The CLINT write port is 64-bit only, so sub-doubleword stores are done as read-modify-write.
- Sits between the LSU MMIO path and CLINT; one transaction in flight.

Parameters:
- CLINT_BASE, 64'h0000_0000_0200_0000, base of the 64 KiB CLINT window (aligned to 64 KiB).
- DATA_W, 64, data width; fixed at 64, only the default is supported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1=store, 0=load
- req_addr_i  in  64  byte address
- req_size_i  in  2  0=B,1=H,2=W,3=D
- req_signed_i  in  1  sign-extend the load result
- req_wdata_i  in  64  store data, right-aligned (low bytes)
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed when valid&ready
- resp_rdata_o  out  64  load result, right-aligned and extended; 0 for stores and errors
- resp_err_o  out  1  access fault
- clint_re_o  out  1  CLINT read strobe
- clint_raddr_o  out  16  CLINT read offset, doubleword-aligned
- clint_rdata_i  in  64  CLINT read data, valid the cycle after re
- clint_we_o  out  1  CLINT write strobe, committed at the next posedge
- clint_waddr_o  out  16  CLINT write offset, doubleword-aligned
- clint_wdata_o  out  64  full doubleword write data

Behaviour:
- Reset (async, any state): state=IDLE; req_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, clint_re_o=0, clint_we_o=0, addr/wdata outputs=0, internal buffers=0. An RMW interrupted by reset issues no write.
- FSM states: IDLE, RD, CAP, WR, RESP. req_ready_o=1 only in IDLE. Strobes are registered outputs, high for exactly one cycle.
- Accept (IDLE, valid): latch we, addr, size, signed, wdata.
  - off = addr[15:0]; lane = addr[2:0].
  - err if addr[63:16] != CLINT_BASE[63:16], or if lane is not a multiple of 2^size.
  - err -> RESP with err=1, rdata=0; no CLINT strobe ever issued.
  - load -> RD.
  - store size 3 -> WR.
  - store size<3 -> RD.
- RD: clint_re_o=1, clint_raddr_o={off[15:3],3'b0}; next CAP.
- CAP: capture clint_rdata_i into dbuf.
  - Load: resp_rdata = (dbuf >> 8*lane) truncated to 2^size bytes, sign- or zero-extended per signed; next RESP.
  - Store: replace bytes lane..lane+2^size-1 of dbuf with the low bytes of wdata; next WR.
- WR: clint_we_o=1, clint_waddr_o={off[15:3],3'b0}, clint_wdata_o = merged dbuf (or wdata for size 3); next RESP.
- RESP: resp_valid_o=1, outputs held stable until resp_ready_i; then IDLE. A new request is accepted no earlier than the cycle after the handshake.
- Latency from acceptance at edge N (resp_valid first high):
  - error: N+1
  - full store: N+2
  - load: N+3
  - partial store: N+4
- Unmapped offsets inside the window are not errors; CLINT returns its last rdata for them. The block forwards that value unchanged.
- No combinational path from req_* or resp_ready_i to any clint_* output.

Decomposition:
- Shared package: size encodings (SZ_B/H/W/D), CLINT_BASE, offsets MTIMECMP_OFF=16'h4000 and MTIME_OFF=16'hBFF8, FSM state typedef.
- One sub-module is natural: clint_lane_align (combinational). Extract/extend for loads, byte-merge for stores, given lane, size, signed. Reused by the LSU.

Test Plan:
- Load D at 0x0200_BFF8, CLINT returns 64'h0000_0000_1234_5678 after re -> re high 1 cycle at raddr 16'hBFF8; resp at N+3, rdata=64'h1234_5678, err=0.
- Load W signed at 0x0200_4004, rdata_i=64'h8000_0001_0000_0000 -> resp_rdata=64'hFFFF_FFFF_8000_0001.
- Store B 8'hAB at 0x0200_4002, CLINT holds 64'h1111_2222_3333_4444 -> re at N+1, we at N+3 with waddr 16'h4000, wdata=64'h1111_2222_33AB_4444; resp at N+4.
- Store D 64'hDEAD_BEEF_0000_0001 at 0x0200_4000 -> no re, one-cycle we at N+1 with exact data; resp at N+2.
- Errors at 0x0300_0000 and at 0x0200_4003 size H -> resp at N+1 with err=1, rdata=0; clint_re/we never asserted.
- Async rst asserted in CAP of a partial store -> all outputs zero immediately, no we afterwards. Hold resp_ready_i=0 for 5 cycles in RESP -> outputs stable and req_ready_o=0 throughout.
